// File: rtl/aes256_cop_controller.sv
// CPU-facing sequencer for the AES-256 CTR co-processor: register bus, key/nonce
// loading, block streaming gated by the datapath FIFO flags, drain wait and done IRQ.
module aes256_cop_controller #(
  parameter int AES_LATENCY = 14,
  parameter int CNT_W       = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   bus_addr,
  input  logic [31:0]  bus_wdata,
  input  logic         bus_we,
  input  logic         bus_re,
  output logic [31:0]  bus_rdata,
  output logic         bus_rvalid,
  output logic         irq,
  output logic [255:0] key_dataout,
  output logic         setkey_ctrout,
  output logic [127:0] nonce_dataout,
  output logic         setnonce_ctrout,
  output logic         run_ctrout,
  output logic [31:0]  user_dataout,
  output logic         wren_ctrout,
  input  logic [31:0]  user_datain,
  output logic         rden_ctrout,
  input  logic         inwordfifofull_ctrin,
  input  logic         outwordfifoempty_ctrin,
  input  logic         inblockfifoempty_ctrin,
  input  logic         outblockfifofull_ctrin
);

  localparam int DRAIN_W = $clog2(AES_LATENCY + 1);

  localparam logic [3:0] ADDR_CTRL    = 4'd12;
  localparam logic [3:0] ADDR_NBLOCKS = 4'd13;
  localparam logic [3:0] ADDR_DATA    = 4'd14;
  localparam logic [3:0] ADDR_STATUS  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    LOADKEY,
    LOADNONCE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [127:0]       nonce_q, nonce_d;
  logic [CNT_W-1:0]   nblocks_q, nblocks_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               cfg_err_q, cfg_err_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rd_pop_q, rd_pop_d;
  logic               status_clr_q, status_clr_d;
  logic               irq_q, irq_d;
  logic               setkey_q, setkey_d;
  logic               setnonce_q, setnonce_d;

  logic        busy;
  logic        done;
  logic        wr_data;
  logic        rd_data;
  logic        run;
  logic [31:0] status_word;

  assign busy = (state_q == LOADKEY) || (state_q == LOADNONCE) ||
                (state_q == RUN)     || (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign status_word = {20'b0,
                        outblockfifofull_ctrin, inblockfifoempty_ctrin,
                        outwordfifoempty_ctrin, inwordfifofull_ctrin,
                        3'b0, cfg_err_q, underflow_q, overflow_q, done, busy};

  // DATA accesses talk to the word FIFOs in the same cycle as the bus strobe.
  assign wr_data = bus_we && (bus_addr == ADDR_DATA);
  assign rd_data = bus_re && (bus_addr == ADDR_DATA);

  assign run = (state_q == RUN) && (remaining_q != '0) &&
               !inblockfifoempty_ctrin && !outblockfifofull_ctrin;

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through this block infers a latch.
    state_d      = state_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    nblocks_d    = nblocks_q;
    remaining_d  = remaining_q;
    drain_cnt_d  = drain_cnt_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    cfg_err_d    = cfg_err_q;
    rvalid_d     = bus_re;
    rdata_d      = '0;
    rd_pop_d     = 1'b0;
    status_clr_d = 1'b0;

    if (bus_re) begin
      unique case (bus_addr)
        ADDR_NBLOCKS: rdata_d = 32'(nblocks_q);
        ADDR_STATUS: begin
          rdata_d      = status_word;
          status_clr_d = 1'b1;
        end
        ADDR_DATA: rd_pop_d = !outwordfifoempty_ctrin;
        default: rdata_d = '0;
      endcase
    end

    // Clear-on-read lands after the response; fresh error events still win.
    if (status_clr_q) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      cfg_err_d   = 1'b0;
    end
    if (wr_data && inwordfifofull_ctrin) overflow_d = 1'b1;
    if (rd_data && outwordfifoempty_ctrin) underflow_d = 1'b1;

    unique case (state_q)
      LOADKEY:   state_d = LOADNONCE;
      LOADNONCE: state_d = RUN;
      RUN: begin
        remaining_d = remaining_q - CNT_W'(run);
        if (remaining_d == '0) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_W'(AES_LATENCY - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) state_d = DONE;
        else drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: ;
    endcase

    // Configuration and control writes come last so abort overrides the sequencer.
    if (bus_we) begin
      if (!bus_addr[3]) begin
        if (busy) cfg_err_d = 1'b1;
        else key_d[{bus_addr[2:0], 5'b0} +: 32] = bus_wdata;
      end else if (bus_addr[3:2] == 2'b10) begin
        if (busy) cfg_err_d = 1'b1;
        else nonce_d[{bus_addr[1:0], 5'b0} +: 32] = bus_wdata;
      end else if (bus_addr == ADDR_NBLOCKS) begin
        if (busy) cfg_err_d = 1'b1;
        else nblocks_d = bus_wdata[CNT_W-1:0];
      end else if (bus_addr == ADDR_CTRL) begin
        if (bus_wdata[1]) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (bus_wdata[0]) begin
          if (busy) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = LOADKEY;
            remaining_d = nblocks_q;
          end
        end
      end
    end

    irq_d      = (state_d == DONE) && (state_q != DONE);
    setkey_d   = (state_d == LOADKEY);
    setnonce_d = (state_d == LOADNONCE);
  end

  // NOTE: key and nonce are ordinary flops that must read zero out of reset; a true RAM array would not get a reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      key_q        <= '0;
      nonce_q      <= '0;
      nblocks_q    <= '0;
      remaining_q  <= '0;
      drain_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rd_pop_q     <= 1'b0;
      status_clr_q <= 1'b0;
      irq_q        <= 1'b0;
      setkey_q     <= 1'b0;
      setnonce_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge _d values together.
      state_q      <= state_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      nblocks_q    <= nblocks_d;
      remaining_q  <= remaining_d;
      drain_cnt_q  <= drain_cnt_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      cfg_err_q    <= cfg_err_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rd_pop_q     <= rd_pop_d;
      status_clr_q <= status_clr_d;
      irq_q        <= irq_d;
      setkey_q     <= setkey_d;
      setnonce_q   <= setnonce_d;
    end
  end

  assign bus_rvalid      = rvalid_q;
  // A popped word is presented by the FIFO one cycle after rden, i.e. in the rvalid cycle.
  assign bus_rdata       = rd_pop_q ? user_datain : rdata_q;
  assign irq             = irq_q;
  assign key_dataout     = key_q;
  assign nonce_dataout   = nonce_q;
  assign setkey_ctrout   = setkey_q;
  assign setnonce_ctrout = setnonce_q;
  assign run_ctrout      = run;
  assign wren_ctrout     = wr_data && !inwordfifofull_ctrin;
  assign user_dataout    = (wr_data && !inwordfifofull_ctrin) ? bus_wdata : '0;
  assign rden_ctrout     = rd_data && !outwordfifoempty_ctrin;

endmodule

// File: tb/tb_aes256_cop_controller.sv
// Self-checking bench for aes256_cop_controller: register reads go through an
// expected-value queue, sequencing events are timed against the bench's own cycle count.
module tb_aes256_cop_controller;

  localparam int L     = 14;
  localparam int CNT_W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_we;
  logic         bus_re;
  logic [31:0]  bus_rdata;
  logic         bus_rvalid;
  logic         irq;
  logic [255:0] key_dataout;
  logic         setkey_ctrout;
  logic [127:0] nonce_dataout;
  logic         setnonce_ctrout;
  logic         run_ctrout;
  logic [31:0]  user_dataout;
  logic         wren_ctrout;
  logic [31:0]  user_datain;
  logic         rden_ctrout;
  logic         inwordfifofull_ctrin;
  logic         outwordfifoempty_ctrin;
  logic         inblockfifoempty_ctrin;
  logic         outblockfifofull_ctrin;

  aes256_cop_controller #(.AES_LATENCY(L), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .irq(irq),
    .key_dataout(key_dataout), .setkey_ctrout(setkey_ctrout),
    .nonce_dataout(nonce_dataout), .setnonce_ctrout(setnonce_ctrout),
    .run_ctrout(run_ctrout), .user_dataout(user_dataout), .wren_ctrout(wren_ctrout),
    .user_datain(user_datain), .rden_ctrout(rden_ctrout),
    .inwordfifofull_ctrin(inwordfifofull_ctrin),
    .outwordfifoempty_ctrin(outwordfifoempty_ctrin),
    .inblockfifoempty_ctrin(inblockfifoempty_ctrin),
    .outblockfifofull_ctrin(outblockfifofull_ctrin)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Event monitor, sampled mid-cycle away from the active edge.
  int run_total = 0, run_start_cyc = 0, last_run_cyc = 0;
  int irq_total = 0, irq_cyc = 0;
  int setkey_total = 0, setkey_cyc = 0, setnonce_cyc = 0;
  int rden_total = 0, wren_total = 0;
  logic [31:0] setkey_word = '0;
  logic run_prev = 1'b0;

  always @(negedge clock) begin
    if (run_ctrout) begin
      if (!run_prev) run_start_cyc = cyc;
      run_total++;
      last_run_cyc = cyc;
    end
    run_prev = run_ctrout;
    if (irq) begin
      irq_total++;
      irq_cyc = cyc;
    end
    if (setkey_ctrout) begin
      setkey_total++;
      setkey_cyc = cyc;
      setkey_word = key_dataout[31:0];
    end
    if (setnonce_ctrout) setnonce_cyc = cyc;
    if (rden_ctrout) rden_total++;
    if (wren_ctrout) wren_total++;
    if (bus_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, 64'(bus_rdata), 64'(mon_e.data));
      end
    end
  end

  int last_wr_cyc = 0;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    tick();
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    last_wr_cyc = cyc;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back('{tag, exp});
    tick();
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    check({tag, "_rvalid"}, 64'(bus_rvalid), 64'(1));
  endtask

  task automatic data_write(input logic [31:0] d);
    logic exp_wren;
    exp_wren = !inwordfifofull_ctrin;
    tick();
    bus_addr = 4'd14; bus_wdata = d; bus_we = 1'b1;
    #1;
    check("wren", 64'(wren_ctrout), 64'(exp_wren));
    if (exp_wren) check("user_dataout", 64'(user_dataout), 64'(d));
    tick();
    bus_we = 1'b0;
  endtask

  // The popped word appears on user_datain only in the cycle after rden.
  task automatic data_read(input logic [31:0] v);
    logic exp_rden;
    exp_rden = !outwordfifoempty_ctrin;
    exp_q.push_back('{"data_rd", exp_rden ? v : 32'h0});
    tick();
    bus_addr = 4'd14; bus_re = 1'b1; user_datain = 32'h0;
    #1;
    check("rden", 64'(rden_ctrout), 64'(exp_rden));
    tick();
    bus_re = 1'b0; user_datain = v;
    check("data_rd_rvalid", 64'(bus_rvalid), 64'(1));
  endtask

  task automatic wait_irq(input int snap, input int budget, input string tag);
    int n = 0;
    while (irq_total == snap && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(irq_total - snap), 64'(1));
  endtask

  int go_cyc, clr_cyc, run0, irq0, sk0, rd0, wr0;

  initial begin
    reset = 1'b1;
    bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    user_datain = 32'hCAFE0000;
    inwordfifofull_ctrin = 1'b0; outwordfifoempty_ctrin = 1'b0;
    inblockfifoempty_ctrin = 1'b0; outblockfifofull_ctrin = 1'b0;
    repeat (3) tick();
    check("rst_key", 64'(key_dataout[63:0]), 64'(0));
    check("rst_setkey", 64'(setkey_ctrout), 64'(0));
    check("rst_run", 64'(run_ctrout), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_rvalid", 64'(bus_rvalid), 64'(0));
    reset = 1'b0;
    bus_read(4'd15, 32'h0, "status_rst");
    bus_read(4'd13, 32'h0, "nblocks_rst");

    // Full sequence: key/nonce load timing, two blocks, drain latency.
    for (int i = 0; i < 8; i++) bus_write(4'(i), 32'h11111111 * 32'(i + 1));
    for (int i = 0; i < 4; i++) bus_write(4'(8 + i), 32'(i));
    bus_write(4'd13, 32'd2);
    bus_read(4'd13, 32'd2, "nblocks_rb");
    bus_read(4'd3, 32'h0, "key_wo_read");
    wr0 = wren_total;
    for (int i = 0; i < 8; i++) data_write(32'hA0000000 + 32'(i));
    check("preload_wren", 64'(wren_total - wr0), 64'(8));
    run0 = run_total; irq0 = irq_total; sk0 = setkey_total;
    bus_write(4'd12, 32'h1);
    go_cyc = last_wr_cyc;
    wait_irq(irq0, 64, "irq_two_blocks");
    check("setkey_cyc", 64'(setkey_cyc - go_cyc), 64'(1));
    check("setkey_word", 64'(setkey_word), 64'(32'h11111111));
    check("setkey_once", 64'(setkey_total - sk0), 64'(1));
    check("setnonce_cyc", 64'(setnonce_cyc - go_cyc), 64'(2));
    check("run_start", 64'(run_start_cyc - go_cyc), 64'(3));
    check("run_count", 64'(run_total - run0), 64'(2));
    check("irq_latency", 64'(irq_cyc - last_run_cyc), 64'(L + 1));
    check("key_top", 64'(key_dataout[255:224]), 64'(32'h88888888));
    check("nonce_top", 64'(nonce_dataout[127:96]), 64'(3));
    bus_read(4'd15, 32'h2, "status_done");

    // Output block FIFO full stalls RUN for five cycles.
    bus_write(4'd13, 32'd3);
    run0 = run_total; irq0 = irq_total;
    outblockfifofull_ctrin = 1'b1;
    bus_write(4'd12, 32'h1);
    go_cyc = last_wr_cyc;
    repeat (5) tick();
    bus_read(4'd15, 32'h801, "status_stalled");
    check("stall_no_run", 64'(run_total - run0), 64'(0));
    outblockfifofull_ctrin = 1'b0;
    clr_cyc = cyc;
    wait_irq(irq0, 64, "irq_stalled");
    check("stall_resume", 64'(run_start_cyc), 64'(clr_cyc));
    check("stall_run_count", 64'(run_total - run0), 64'(3));
    check("stall_irq_latency", 64'(irq_cyc - last_run_cyc), 64'(L + 1));

    // Overflow on a full input word FIFO, cleared by the status read.
    wr0 = wren_total;
    inwordfifofull_ctrin = 1'b1;
    data_write(32'h55);
    inwordfifofull_ctrin = 1'b0;
    check("ovf_no_wren", 64'(wren_total - wr0), 64'(0));
    bus_read(4'd15, 32'h6, "status_ovf");
    bus_read(4'd15, 32'h2, "status_ovf_clr");

    // Underflow on an empty output word FIFO, then a real pop.
    rd0 = rden_total;
    outwordfifoempty_ctrin = 1'b1;
    data_read(32'h1234);
    check("udf_no_rden", 64'(rden_total - rd0), 64'(0));
    bus_read(4'd15, 32'h20A, "status_udf");
    bus_read(4'd15, 32'h202, "status_udf_clr");
    outwordfifoempty_ctrin = 1'b0;
    data_read(32'hBEEF0001);
    check("pop_rden", 64'(rden_total - rd0), 64'(1));

    // Abort during DRAIN: back to IDLE, no irq, done clear.
    bus_write(4'd13, 32'd1);
    run0 = run_total; irq0 = irq_total;
    bus_write(4'd12, 32'h1);
    repeat (5) tick();
    bus_write(4'd12, 32'h2);
    repeat (L + 5) tick();
    check("abort_no_irq", 64'(irq_total - irq0), 64'(0));
    check("abort_run_count", 64'(run_total - run0), 64'(1));
    bus_read(4'd15, 32'h0, "status_abort");

    // go and abort together: abort wins, nothing starts.
    sk0 = setkey_total;
    bus_write(4'd12, 32'h3);
    repeat (3) tick();
    check("goabort_no_start", 64'(setkey_total - sk0), 64'(0));
    bus_read(4'd15, 32'h0, "status_goabort");

    // Config writes and go while busy are ignored and flag cfg_err.
    irq0 = irq_total; sk0 = setkey_total;
    bus_write(4'd12, 32'h1);
    bus_write(4'd0, 32'hDEADBEEF);
    bus_write(4'd12, 32'h1);
    check("busy_key_kept", 64'(key_dataout[31:0]), 64'(32'h11111111));
    wait_irq(irq0, 64, "irq_busy");
    check("busy_go_ignored", 64'(setkey_total - sk0), 64'(1));
    bus_read(4'd15, 32'h12, "status_cfg_err");
    bus_read(4'd15, 32'h2, "status_cfg_clr");

    // Reset mid-RUN clears the buses, then NBLOCKS=0 passes straight through.
    bus_write(4'd12, 32'h1);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("midrst_key", 64'(key_dataout[31:0]), 64'(0));
    check("midrst_nonce", 64'(nonce_dataout[63:32]), 64'(0));
    check("midrst_setnonce", 64'(setnonce_ctrout), 64'(0));
    tick();
    reset = 1'b0;
    bus_read(4'd15, 32'h0, "status_midrst");
    run0 = run_total; irq0 = irq_total;
    bus_write(4'd12, 32'h1);
    go_cyc = last_wr_cyc;
    wait_irq(irq0, 64, "irq_zero_blocks");
    check("zero_run_count", 64'(run_total - run0), 64'(0));
    check("zero_irq_cyc", 64'(irq_cyc - go_cyc), 64'(L + 4));

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes256_cop_controller.md
Name: aes256_cop_controller

Overview:
CPU-facing sequencer for the AES-256 CTR co-processor datapath. Exposes a 16-word register bus to the MIPS core and drives every datapath control input: key and nonce buses and their load strobes, run, data write/read strobes. Loads the key and nonce, streams a programmed number of blocks through the datapath using its FIFO flags, waits out engine latency, then signals done/IRQ.

Parameters:
AES_LATENCY, 14, cycles from the last run pulse until the final block is in the output block FIFO.
CNT_W, 16, width of the block-count register.

Ports:
clock  in  1  system clock
reset  in  1  async active-high reset
bus_addr  in  4  register word index
bus_wdata  in  32  write data
bus_we  in  1  write strobe, one cycle per access
bus_re  in  1  read strobe, one cycle per access
bus_rdata  out  32  read data, valid with bus_rvalid
bus_rvalid  out  1  read response, one cycle
irq  out  1  one-cycle pulse on entry to DONE
key_dataout  out  256  key bus to datapath
setkey_ctrout  out  1  key load strobe
nonce_dataout  out  128  nonce bus
setnonce_ctrout  out  1  nonce load strobe
run_ctrout  out  1  datapath run
user_dataout  out  32  word to datapath input
wren_ctrout  out  1  push word to input word FIFO
user_datain  in  32  word from output word FIFO
rden_ctrout  out  1  pop output word FIFO
inwordfifofull_ctrin, outwordfifoempty_ctrin, inblockfifoempty_ctrin, outblockfifofull_ctrin  in  1 each  datapath FIFO flags

Behaviour:
- Reset: all outputs 0, key/nonce/count registers 0, state IDLE, sticky errors 0.
- Register map: 0-7 KEYi (W, bits 32i+31:32i); 8-11 NONCEi (W); 12 CTRL (W: bit0 go, bit1 abort); 13 NBLOCKS (R/W, low CNT_W bits); 14 DATA (R/W); 15 STATUS (R: bit0 busy, bit1 done, bit2 overflow, bit3 underflow, bit4 cfg_err, bits 11:8 the four FIFO flags). Reads of write-only registers return 0.
- Reads: bus_rvalid exactly 1 cycle after bus_re; STATUS read clears bits 2-4 (clear-on-read, effective the cycle after rvalid).
- DATA write: wren_ctrout and user_dataout asserted same cycle as bus_we if inwordfifofull=0; otherwise word dropped, overflow set. Allowed in any state.
- DATA read: rden_ctrout asserted in bus_re cycle if outwordfifoempty=0; bus_rdata = user_datain sampled next cycle. If empty: no rden, rdata=0, underflow set.
- FSM: IDLE -> LOADKEY (setkey 1 cycle) -> LOADNONCE (setnonce 1 cycle) -> RUN -> DRAIN -> DONE.
- go in IDLE or DONE at cycle t: LOADKEY at t+1, LOADNONCE t+2, RUN t+3; remaining <= NBLOCKS on go; done cleared.
- RUN: run_ctrout = (remaining!=0) & ~inblockfifoempty & ~outblockfifofull, combinational from state/flags; remaining decrements on each run cycle. remaining==0 -> DRAIN next cycle (NBLOCKS=0 passes through RUN for 1 cycle).
- DRAIN: counter runs AES_LATENCY cycles, then DONE; irq pulses on DONE entry; done=1, busy=0 in DONE/IDLE, busy=1 elsewhere.
- abort: any state -> IDLE next cycle; run/strobes 0 from that cycle; remaining cleared; done not set; no irq. go+abort in one write: abort wins.
- go while busy: ignored, cfg_err set. KEY/NONCE/NBLOCKS writes while busy: ignored, cfg_err set.
- Counter wrap impossible: remaining only decrements while nonzero.
- Reset mid-operation: immediate return to reset values, including key/nonce buses.

Test Plan:
- Write KEY0-7=0x11111111..0x88888888, NONCE=0..3, NBLOCKS=2, go -> setkey at t+1 with key_dataout[31:0]=0x11111111, setnonce at t+2, RUN at t+3.
- Preload 8 DATA words, NBLOCKS=2, go -> exactly 2 run cycles, irq AES_LATENCY+1 cycles after last run, STATUS=0x2 plus flags.
- Hold outblockfifofull=1 for 5 cycles during RUN -> run_ctrout 0 throughout, remaining unchanged, resumes when flag clears.
- DATA write with inwordfifofull=1 -> no wren, STATUS bit2=1; second STATUS read -> bit2=0.
- DATA read with outwordfifoempty=1 -> rvalid next cycle, rdata=0, underflow set, rden never high.
- Abort during DRAIN; go+abort together; KEY write while busy -> IDLE no irq; no start; cfg_err=1, key_dataout unchanged.
